// File: rtl/traffic_phase_sequencer_if.sv
// Signal bundle between the intersection controller and its sensors and lamps.
// ped_req is a level request; ped_ack is a one-cycle acknowledge when the request is actually served.
interface traffic_phase_sequencer_if;
    logic       x;
    logic       ped_req;
    logic       ped_ack;
    logic       walk;
    logic [1:0] hwy;
    logic [1:0] cntry;
    logic [2:0] phase;  // current FSM state, exported for observation

    modport master (
        output x,
        output ped_req,
        input  ped_ack,
        input  walk,
        input  hwy,
        input  cntry,
        input  phase
    );

    modport slave (
        input  x,
        input  ped_req,
        output ped_ack,
        output walk,
        output hwy,
        output cntry,
        output phase
    );
endinterface

// File: rtl/traffic_phase_sequencer.sv
// Highway / country-road traffic light sequencer with an optional pedestrian walk phase.
// Define TRAFFIC_PED_REQ_EN to compile in the pedestrian request/acknowledge/walk logic.
module traffic_phase_sequencer #(
    parameter int unsigned HWY_MIN    = 10,
    parameter int unsigned Y_TICKS    = 3,
    parameter int unsigned RR_TICKS   = 2,
    parameter int unsigned CNTRY_MAX  = 8,
    parameter int unsigned WALK_TICKS = 4
) (
    input logic                      clock,
    input logic                      clear,
    traffic_phase_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        HG  = 3'd0,
        HY  = 3'd1,
        AR1 = 3'd2,
        CG  = 3'd3,
        CY  = 3'd4,
        AR2 = 3'd5
    } phase_t;

    localparam logic [1:0] RED    = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] GREEN  = 2'b10;

    localparam logic [7:0] HWY_LOAD   = 8'(HWY_MIN - 1);
    localparam logic [7:0] Y_LOAD     = 8'(Y_TICKS - 1);
    localparam logic [7:0] RR_LOAD    = 8'(RR_TICKS - 1);
    localparam logic [7:0] CG_LOAD    = 8'(CNTRY_MAX - 1);
    // Timer value at the end of CG cycle WALK_TICKS (timer counts CNTRY_MAX-1 down to 0).
    localparam logic [7:0] WALK_DONE  = 8'(CNTRY_MAX - WALK_TICKS);

    phase_t     state;
    phase_t     state_next;
    logic [7:0] timer;
    logic [7:0] timer_next;
    logic       ped_go;
    logic       walk_min_ok;
    logic [1:0] hwy_lamp;
    logic [1:0] cntry_lamp;

`ifdef TRAFFIC_PED_REQ_EN
    logic ped_req_q;
    logic ped_pending;
    logic ped_ack_r;
    logic walk_r;
    logic ped_rise;
    logic serve;

    assign ped_rise = bus.ped_req & ~ped_req_q;
    // Serve happens on the edge that moves AR1 into CG.
    assign serve    = (state == AR1) && (timer == 8'd0) && ped_pending;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            ped_req_q   <= 1'b0;
            ped_pending <= 1'b0;
            ped_ack_r   <= 1'b0;
            walk_r      <= 1'b0;
        end else begin
            ped_req_q   <= bus.ped_req;
            // A fresh rising edge wins over the clear caused by serving.
            ped_pending <= ped_rise | (ped_pending & ~serve);
            ped_ack_r   <= serve;
            walk_r      <= (state_next == CG) && (serve || walk_r);
        end
    end

    assign ped_go      = ped_pending;
    assign walk_min_ok = ~walk_r || (timer <= WALK_DONE);
    assign bus.ped_ack = ped_ack_r;
    assign bus.walk    = walk_r;
`else
    logic unused_ped_req;

    assign unused_ped_req = bus.ped_req;
    assign ped_go         = 1'b0;
    assign walk_min_ok    = 1'b1;
    assign bus.ped_ack    = 1'b0;
    assign bus.walk       = 1'b0;
`endif

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state <= HG;
            timer <= HWY_LOAD;
        end else begin
            state <= state_next;
            timer <= timer_next;
        end
    end

    always_comb begin
        state_next = state;
        timer_next = (timer == 8'd0) ? 8'd0 : timer - 8'd1;
        case (state)
            HG: begin
                if (timer == 8'd0 && (bus.x || ped_go)) begin
                    state_next = HY;
                    timer_next = Y_LOAD;
                end
            end
            HY: begin
                if (timer == 8'd0) begin
                    state_next = AR1;
                    timer_next = RR_LOAD;
                end
            end
            AR1: begin
                if (timer == 8'd0) begin
                    state_next = CG;
                    timer_next = CG_LOAD;
                end
            end
            CG: begin
                // timer==0 here means CG has run its full CNTRY_MAX cycles.
                if (timer == 8'd0 || (!bus.x && walk_min_ok)) begin
                    state_next = CY;
                    timer_next = Y_LOAD;
                end
            end
            CY: begin
                if (timer == 8'd0) begin
                    state_next = AR2;
                    timer_next = RR_LOAD;
                end
            end
            AR2: begin
                if (timer == 8'd0) begin
                    state_next = HG;
                    timer_next = HWY_LOAD;
                end
            end
            default: begin
                state_next = HG;
                timer_next = HWY_LOAD;
            end
        endcase
    end

    always_comb begin
        hwy_lamp   = RED;
        cntry_lamp = RED;
        case (state)
            HG:      hwy_lamp   = GREEN;
            HY:      hwy_lamp   = YELLOW;
            CG:      cntry_lamp = GREEN;
            CY:      cntry_lamp = YELLOW;
            default: begin
                hwy_lamp   = RED;
                cntry_lamp = RED;
            end
        endcase
    end

    assign bus.hwy   = hwy_lamp;
    assign bus.cntry = cntry_lamp;
    assign bus.phase = state;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Bench for traffic_phase_sequencer: a lamp monitor cuts the output into constant-lamp segments
// and compares each {lamp, length} against expectations queued when the stimulus is applied.
module tb_traffic_phase_sequencer;

    localparam int HWY_MIN    = 10;
    localparam int Y_TICKS    = 3;
    localparam int RR_TICKS   = 2;
    localparam int CNTRY_MAX  = 8;
    localparam int WALK_TICKS = 4;

    localparam logic [1:0] RED    = 2'b00;
    localparam logic [1:0] GREEN  = 2'b10;

    // Lamp code = {hwy, cntry, walk}
    localparam logic [4:0] HG_L  = 5'b10_00_0;
    localparam logic [4:0] HY_L  = 5'b01_00_0;
    localparam logic [4:0] AR_L  = 5'b00_00_0;
    localparam logic [4:0] CG_L  = 5'b00_10_0;
    localparam logic [4:0] CY_L  = 5'b00_01_0;
`ifdef TRAFFIC_PED_REQ_EN
    localparam logic [4:0] CGW_L = 5'b00_10_1;
`endif

    logic clock = 1'b0;
    logic clear = 1'b1;
    always #5 clock = ~clock;

    traffic_phase_sequencer_if bus();

    traffic_phase_sequencer #(
        .HWY_MIN   (HWY_MIN),
        .Y_TICKS   (Y_TICKS),
        .RR_TICKS  (RR_TICKS),
        .CNTRY_MAX (CNTRY_MAX),
        .WALK_TICKS(WALK_TICKS)
    ) dut (
        .clock(clock),
        .clear(clear),
        .bus  (bus)
    );

    int          n_compared   = 0;
    int          n_mismatched = 0;
    logic [12:0] exp_q[$];
    logic [4:0]  run_lamp;
    int          run_len      = 0;
    int          ack_count    = 0;
    logic [4:0]  mon_lamp;
    logic        mon_first_cg;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [12:0] seg(input logic [4:0] lamp, input int len);
        return {lamp, 8'(len)};
    endfunction

    // Lamp monitor, sampling mid-cycle
    always @(negedge clock) begin
        if (clear) begin
            run_len = 0;
        end else begin
            mon_lamp     = {bus.hwy, bus.cntry, bus.walk};
            mon_first_cg = (bus.cntry == GREEN) && (run_len == 0 || run_lamp[2:1] != GREEN);
            check_eq("lamp_legal",
                     (bus.hwy != 2'b11 && bus.cntry != 2'b11 &&
                      (bus.hwy == RED || bus.cntry == RED)) ? 32'd1 : 32'd0, 32'd1);
            check_eq("walk_outside_cg", {31'd0, bus.walk && (bus.cntry != GREEN)}, 32'd0);
            check_eq("ack_outside_first_cg", {31'd0, bus.ped_ack && !mon_first_cg}, 32'd0);
            if (bus.ped_ack) ack_count++;
            if (run_len != 0 && mon_lamp != run_lamp) begin
                if (exp_q.size() == 0)
                    check_eq("seg_extra", {19'd0, seg(run_lamp, run_len)}, 32'd0);
                else
                    check_eq("seg", {19'd0, seg(run_lamp, run_len)}, {19'd0, exp_q.pop_front()});
                run_len = 0;
            end
            run_lamp = mon_lamp;
            run_len++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic do_reset();
        @(posedge clock);
        #2;
        clear       = 1'b1;
        bus.x       = 1'b0;
        bus.ped_req = 1'b0;
        #1;
        check_eq("rst_hwy",     {30'd0, bus.hwy},   {30'd0, GREEN});
        check_eq("rst_cntry",   {30'd0, bus.cntry}, {30'd0, RED});
        check_eq("rst_walk",    {31'd0, bus.walk},    32'd0);
        check_eq("rst_ped_ack", {31'd0, bus.ped_ack}, 32'd0);
        check_eq("rst_phase",   {29'd0, bus.phase},   32'd0);
        ack_count = 0;
        tick(1);
        clear = 1'b0;
    endtask

    task automatic push_cycle(input logic [4:0] cg_lamp, input int cg_len);
        exp_q.push_back(seg(HG_L, HWY_MIN));
        exp_q.push_back(seg(HY_L, Y_TICKS));
        exp_q.push_back(seg(AR_L, RR_TICKS));
        exp_q.push_back(seg(cg_lamp, cg_len));
        exp_q.push_back(seg(CY_L, Y_TICKS));
        exp_q.push_back(seg(AR_L, RR_TICKS));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            tick(1);
            n++;
        end
        check_eq("drain_timeout", exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        bus.x       = 1'b0;
        bus.ped_req = 1'b0;

        // Full cycle with the country sensor held: CG capped at CNTRY_MAX
        do_reset();
        bus.x = 1'b1;
        push_cycle(CG_L, CNTRY_MAX);
        exp_q.push_back(seg(HG_L, HWY_MIN));
        drain();

        // Country traffic leaves in CG cycle 5: CG lasts 5 cycles, then HG holds
        do_reset();
        bus.x = 1'b1;
        push_cycle(CG_L, 5);
        tick(HWY_MIN + Y_TICKS + RR_TICKS + 4);
        bus.x = 1'b0;
        drain();
        tick(5);
        check_eq("cg_early_back_hg", {27'd0, run_lamp}, {27'd0, HG_L});

        // No demand: highway stays green for 100 cycles
        do_reset();
        tick(100);
        check_eq("idle_lamp", {27'd0, run_lamp}, {27'd0, HG_L});
        check_eq("idle_len",  run_len, 32'd100);
        check_eq("idle_ack",  ack_count, 32'd0);

        // Clear asserted between edges in the middle of CG
        do_reset();
        bus.x = 1'b1;
        exp_q.push_back(seg(HG_L, HWY_MIN));
        exp_q.push_back(seg(HY_L, Y_TICKS));
        exp_q.push_back(seg(AR_L, RR_TICKS));
        tick(1);
        bus.ped_req = 1'b1;
        tick(HWY_MIN + Y_TICKS + RR_TICKS + 1);
        #1;
        check_eq("mid_cg_phase", {29'd0, bus.phase}, 32'd3);
        clear = 1'b1;
        #1;
        check_eq("mid_clr_hwy",   {30'd0, bus.hwy},   {30'd0, GREEN});
        check_eq("mid_clr_cntry", {30'd0, bus.cntry}, {30'd0, RED});
        check_eq("mid_clr_walk",  {31'd0, bus.walk},    32'd0);
        check_eq("mid_clr_ack",   {31'd0, bus.ped_ack}, 32'd0);
        drain();

`ifdef TRAFFIC_PED_REQ_EN
        // Pedestrian request rising in cycle 2, held 30 cycles: one service, walk 4 cycles
        do_reset();
        tick(1);
        bus.ped_req = 1'b1;
        push_cycle(CGW_L, WALK_TICKS);
        tick(30);
        bus.ped_req = 1'b0;
        drain();
        tick(20);
        check_eq("ped_back_hg", {27'd0, run_lamp}, {27'd0, HG_L});
        check_eq("ped_ack_count", ack_count, 32'd1);
`else
        // Pedestrian input ignored when the feature is compiled out
        do_reset();
        repeat (60) begin
            bus.ped_req = 1'($urandom_range(0, 1));
            tick(1);
        end
        check_eq("noped_lamp", {27'd0, run_lamp}, {27'd0, HG_L});
        check_eq("noped_len",  run_len, 32'd60);
        check_eq("noped_ack",  ack_count, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
